// File: rtl/snake_pkg.sv
// Shared encodings for the snake game blocks: controller, body, apple generator and VGA renderer.
package snake_pkg;

    localparam int COORD_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DIE  = 2'd2,
        ST_OVER = 2'd3
    } game_state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    // Opposite directions differ only in the LSB of the encoding.
    function automatic dir_e dir_reverse(input dir_e d);
        return dir_e'({d[1], ~d[0]});
    endfunction

endpackage

// File: rtl/snake_step_timer.sv
// Step timer: counts 0..period-1 while running and emits a registered one-cycle tick per wrap.
// The combinational wrap flag lets the controller update state on the same edge that raises the tick.
module snake_step_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             clr,
    input  logic [CNT_W-1:0] period,
    output logic             wrap,
    output logic             step_tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        wrap   = run && !clr && (cnt_q == period - CNT_W'(1));
        cnt_d  = cnt_q + CNT_W'(1);
        if (clr || !run || wrap) begin
            cnt_d = '0;
        end
        tick_d = wrap;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign step_tick = tick_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: game FSM, direction, head coordinate, body length and score.
// Optional SNAKE_SPEEDUP_EN shortens the step period every 4th apple.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int STEP_CYCLES = 12_500_000,
    parameter int X_MAX       = 38,
    parameter int Y_MAX       = 28,
    parameter int START_X     = 10,
    parameter int START_Y     = 5,
    parameter int LEN_MAX     = 32,
    parameter int DIE_STEPS   = 8
) (
    input  logic               Clk_50mhz,
    input  logic               Rst_n,
    input  logic               Key_up,
    input  logic               Key_down,
    input  logic               Key_left,
    input  logic               Key_right,
    input  logic               Key_start,
    input  logic               Body_add_sig,
    input  logic               Body_hit,
    output logic [1:0]         Game_state,
    output logic [COORD_W-1:0] Head_x,
    output logic [COORD_W-1:0] Head_y,
    output logic [1:0]         Dir,
    output logic               Step_tick,
    output logic [5:0]         Body_len,
    output logic [7:0]         Score,
    output logic               Flash
);

    localparam int CNT_W = $clog2(STEP_CYCLES + 1);
    localparam int DIE_W = (DIE_STEPS > 1) ? $clog2(DIE_STEPS) : 1;

    localparam logic [COORD_W-1:0] START_X_C = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] START_Y_C = COORD_W'(START_Y);
    localparam logic [COORD_W-1:0] X_MAX_C   = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] Y_MAX_C   = COORD_W'(Y_MAX);
    localparam logic [5:0]         LEN_INIT  = 6'd3;
    localparam logic [5:0]         LEN_MAX_C = 6'(LEN_MAX);
    localparam logic [DIE_W-1:0]   DIE_LAST  = DIE_W'(DIE_STEPS - 1);

    game_state_e        state_q, state_d;
    dir_e               dir_q, dir_d, pend_q, pend_d, pend_next, key_dir;
    logic [COORD_W-1:0] head_x_q, head_x_d, head_y_q, head_y_d, nx, ny;
    logic [5:0]         len_q, len_d;
    logic [7:0]         score_q, score_d;
    logic               flash_q, flash_d;
    logic [DIE_W-1:0]   die_cnt_q, die_cnt_d;

    logic               step, start_play, apple, key_any, hit_wall, die_last;
    logic [CNT_W-1:0]   period;

    assign start_play = (state_q == ST_IDLE) && Key_start;
    assign apple      = (state_q == ST_PLAY) && Body_add_sig;
    assign die_last   = (die_cnt_q == DIE_LAST);

    snake_step_timer #(.CNT_W(CNT_W)) u_timer (
        .clk       (Clk_50mhz),
        .rst_n     (Rst_n),
        .run       ((state_q == ST_PLAY) || (state_q == ST_DIE)),
        .clr       (start_play),
        .period    (period),
        .wrap      (step),
        .step_tick (Step_tick)
    );

`ifdef SNAKE_SPEEDUP_EN
    localparam logic [CNT_W-1:0] PERIOD_INIT = CNT_W'(STEP_CYCLES);
    localparam logic [CNT_W-1:0] PERIOD_DEC  = CNT_W'(STEP_CYCLES / 16);
    localparam logic [CNT_W-1:0] PERIOD_MIN  = CNT_W'(STEP_CYCLES / 4);

    // speed_q is the target period; period_q follows it only at a timer wrap.
    logic [CNT_W-1:0] speed_q, speed_d, period_q, period_d;

    always_comb begin
        speed_d  = speed_q;
        period_d = period_q;
        if (start_play) begin
            speed_d  = PERIOD_INIT;
            period_d = PERIOD_INIT;
        end else begin
            if (apple && (score_q[1:0] == 2'b11) && (score_q != 8'hFF)) begin
                speed_d = (speed_q >= PERIOD_MIN + PERIOD_DEC) ? speed_q - PERIOD_DEC : PERIOD_MIN;
            end
            if (step) begin
                period_d = speed_q;
            end
        end
    end

    always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            speed_q  <= PERIOD_INIT;
            period_q <= PERIOD_INIT;
        end else begin
            speed_q  <= speed_d;
            period_q <= period_d;
        end
    end

    assign period = period_q;
`else
    assign period = CNT_W'(STEP_CYCLES);
`endif

    // Key arbitration, candidate head and wall test.
    always_comb begin
        key_any = Key_up | Key_down | Key_left | Key_right;
        key_dir = DIR_RIGHT;
        if (Key_up)        key_dir = DIR_UP;
        else if (Key_down) key_dir = DIR_DOWN;
        else if (Key_left) key_dir = DIR_LEFT;

        pend_next = pend_q;
        if ((state_q == ST_PLAY) && key_any && (key_dir != dir_reverse(dir_q))) begin
            pend_next = key_dir;
        end

        nx = head_x_q;
        ny = head_y_q;
        case (pend_next)
            DIR_UP:   ny = head_y_q - COORD_W'(1);
            DIR_DOWN: ny = head_y_q + COORD_W'(1);
            DIR_LEFT: nx = head_x_q - COORD_W'(1);
            default:  nx = head_x_q + COORD_W'(1);
        endcase
        hit_wall = (nx == '0) || (nx > X_MAX_C) || (ny == '0) || (ny > Y_MAX_C);
    end

    always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
        if (!Rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (Key_start)                    state_d = ST_PLAY;
            ST_PLAY: if (step && (hit_wall || Body_hit)) state_d = ST_DIE;
            ST_DIE:  if (step && die_last)             state_d = ST_OVER;
            default: if (Key_start)                    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        head_x_d  = head_x_q;
        head_y_d  = head_y_q;
        dir_d     = dir_q;
        pend_d    = pend_next;
        len_d     = len_q;
        score_d   = score_q;
        flash_d   = flash_q;
        die_cnt_d = die_cnt_q;
        if (start_play) begin
            head_x_d  = START_X_C;
            head_y_d  = START_Y_C;
            dir_d     = DIR_RIGHT;
            pend_d    = DIR_RIGHT;
            len_d     = LEN_INIT;
            score_d   = '0;
            flash_d   = 1'b0;
            die_cnt_d = '0;
        end else begin
            if ((state_q == ST_PLAY) && step) begin
                dir_d = pend_next;
                if (!(hit_wall || Body_hit)) begin
                    head_x_d = nx;
                    head_y_d = ny;
                end
            end
            if ((state_q == ST_DIE) && step) begin
                flash_d   = die_last ? 1'b0 : ~flash_q;
                die_cnt_d = die_last ? '0 : die_cnt_q + DIE_W'(1);
            end
            if (apple) begin
                if (len_q != LEN_MAX_C) len_d   = len_q + 6'd1;
                if (score_q != 8'hFF)   score_d = score_q + 8'd1;
            end
        end
    end

    always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            head_x_q  <= START_X_C;
            head_y_q  <= START_Y_C;
            dir_q     <= DIR_RIGHT;
            pend_q    <= DIR_RIGHT;
            len_q     <= LEN_INIT;
            score_q   <= '0;
            flash_q   <= 1'b0;
            die_cnt_q <= '0;
        end else begin
            head_x_q  <= head_x_d;
            head_y_q  <= head_y_d;
            dir_q     <= dir_d;
            pend_q    <= pend_d;
            len_q     <= len_d;
            score_q   <= score_d;
            flash_q   <= flash_d;
            die_cnt_q <= die_cnt_d;
        end
    end

    assign Game_state = state_q;
    assign Head_x     = head_x_q;
    assign Head_y     = head_y_q;
    assign Dir        = dir_q;
    assign Body_len   = len_q;
    assign Score      = score_q;
    assign Flash      = flash_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with STEP_CYCLES=8 (64 with SNAKE_SPEEDUP_EN) and DIE_STEPS=2.
module tb_snake_game_ctrl;

`ifdef SNAKE_SPEEDUP_EN
    localparam int STEP = 64;
`else
    localparam int STEP = 8;
`endif
    localparam int BUDGET = 4 * STEP + 8;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
    logic       key_start = 1'b0, body_add = 1'b0, body_hit = 1'b0;
    logic [1:0] game_state, dir;
    logic [5:0] head_x, head_y, body_len;
    logic [7:0] score;
    logic       step_tick, flash;

    int n_pass = 0;
    int n_total = 0;

    snake_game_ctrl #(
        .STEP_CYCLES (STEP),
        .DIE_STEPS   (2)
    ) dut (
        .Clk_50mhz    (clk),
        .Rst_n        (rst_n),
        .Key_up       (key_up),
        .Key_down     (key_down),
        .Key_left     (key_left),
        .Key_right    (key_right),
        .Key_start    (key_start),
        .Body_add_sig (body_add),
        .Body_hit     (body_hit),
        .Game_state   (game_state),
        .Head_x       (head_x),
        .Head_y       (head_y),
        .Dir          (dir),
        .Step_tick    (step_tick),
        .Body_len     (body_len),
        .Score        (score),
        .Flash        (flash)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_step(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (step_tick !== 1'b1 && n < BUDGET);
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_total++;
        if ({game_state, dir, step_tick, flash} !== {2'd0, 2'd3, 1'b0, 1'b0})
            $display("FAIL reset_ctl state=%0d dir=%0d tick=%0b flash=%0b want 0/3/0/0", game_state, dir, step_tick, flash);
        else n_pass++;
        n_total++;
        if ({head_x, head_y} !== {6'd10, 6'd5})
            $display("FAIL reset_head got (%0d,%0d) want (10,5)", head_x, head_y);
        else n_pass++;
        n_total++;
        if ({body_len, score} !== {6'd3, 8'd0})
            $display("FAIL reset_len_score got %0d/%0d want 3/0", body_len, score);
        else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_idle();
        int ticks = 0;
        key_up = 1'b1;
        tick();
        key_up = 1'b0;
        repeat (2 * STEP) begin
            tick();
            if (step_tick) ticks++;
        end
        n_total++;
        if ({game_state, dir, 6'(ticks)} !== {2'd0, 2'd3, 6'd0})
            $display("FAIL idle_hold state=%0d dir=%0d ticks=%0d want 0/3/0", game_state, dir, ticks);
        else n_pass++;
    endtask

    task automatic test_start();
        int n;
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        n_total++;
        if ({game_state, head_x, head_y} !== {2'd1, 6'd10, 6'd5})
            $display("FAIL start_play state=%0d head=(%0d,%0d) want 1 (10,5)", game_state, head_x, head_y);
        else n_pass++;
        wait_step(n);
        n_total++;
        if (n !== STEP)
            $display("FAIL first_step_latency got %0d want %0d", n, STEP);
        else n_pass++;
        n_total++;
        if ({dir, head_x, head_y} !== {2'd3, 6'd11, 6'd5})
            $display("FAIL first_step_head dir=%0d head=(%0d,%0d) want 3 (11,5)", dir, head_x, head_y);
        else n_pass++;
    endtask

    task automatic test_direction();
        int n;
        key_left  = 1'b1;
        key_start = 1'b1;
        tick();
        key_left  = 1'b0;
        key_start = 1'b0;
        n_total++;
        if (game_state !== 2'd1)
            $display("FAIL start_in_play state=%0d want 1", game_state);
        else n_pass++;
        wait_step(n);
        n_total++;
        if ({6'(n), dir, head_x, head_y} !== {6'(STEP - 1), 2'd3, 6'd12, 6'd5})
            $display("FAIL reverse_ignored n=%0d dir=%0d head=(%0d,%0d) want %0d 3 (12,5)", n, dir, head_x, head_y, STEP - 1);
        else n_pass++;
        key_up   = 1'b1;
        key_down = 1'b1;
        tick();
        key_up   = 1'b0;
        key_down = 1'b0;
        wait_step(n);
        n_total++;
        if ({dir, head_x, head_y} !== {2'd0, 6'd12, 6'd4})
            $display("FAIL key_priority dir=%0d head=(%0d,%0d) want 0 (12,4)", dir, head_x, head_y);
        else n_pass++;
    endtask

    task automatic test_grow();
        body_add = 1'b1;
        repeat (3) tick();
        body_add = 1'b0;
        n_total++;
        if ({body_len, score} !== {6'd6, 8'd3})
            $display("FAIL grow_three got %0d/%0d want 6/3", body_len, score);
        else n_pass++;
    endtask

    task automatic test_wall_die();
        int n;
        wait_step(n);
        n_total++;
        if ({head_x, head_y} !== {6'd12, 6'd3})
            $display("FAIL resync_head got (%0d,%0d) want (12,3)", head_x, head_y);
        else n_pass++;
        repeat (STEP - 1) tick();
        key_right = 1'b1;
        tick();
        key_right = 1'b0;
        n_total++;
        if ({step_tick, dir, head_x, head_y} !== {1'b1, 2'd3, 6'd13, 6'd3})
            $display("FAIL late_key tick=%0b dir=%0d head=(%0d,%0d) want 1 3 (13,3)", step_tick, dir, head_x, head_y);
        else n_pass++;
        repeat (25) wait_step(n);
        n_total++;
        if ({game_state, head_x, head_y} !== {2'd1, 6'd38, 6'd3})
            $display("FAIL at_wall state=%0d head=(%0d,%0d) want 1 (38,3)", game_state, head_x, head_y);
        else n_pass++;
        wait_step(n);
        n_total++;
        if ({game_state, head_x, flash} !== {2'd2, 6'd38, 1'b0})
            $display("FAIL wall_die state=%0d x=%0d flash=%0b want 2 38 0", game_state, head_x, flash);
        else n_pass++;
        wait_step(n);
        n_total++;
        if ({game_state, flash, head_x} !== {2'd2, 1'b1, 6'd38})
            $display("FAIL die_flash state=%0d flash=%0b x=%0d want 2 1 38", game_state, flash, head_x);
        else n_pass++;
        wait_step(n);
        n_total++;
        if ({game_state, flash} !== {2'd3, 1'b0})
            $display("FAIL die_to_over state=%0d flash=%0b want 3 0", game_state, flash);
        else n_pass++;
    endtask

    task automatic test_over();
        int ticks = 0;
        body_add = 1'b1;
        tick();
        body_add = 1'b0;
        repeat (2 * STEP) begin
            tick();
            if (step_tick) ticks++;
        end
        n_total++;
        if ({body_len, score, 6'(ticks), head_x} !== {6'd6, 8'd3, 6'd0, 6'd38})
            $display("FAIL over_hold len=%0d score=%0d ticks=%0d x=%0d want 6 3 0 38", body_len, score, ticks, head_x);
        else n_pass++;
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        n_total++;
        if (game_state !== 2'd0)
            $display("FAIL over_to_idle state=%0d want 0", game_state);
        else n_pass++;
    endtask

    task automatic test_body_hit_reset();
        int n;
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        n_total++;
        if ({game_state, body_len, score, head_x, head_y} !== {2'd1, 6'd3, 8'd0, 6'd10, 6'd5})
            $display("FAIL restart_reload state=%0d len=%0d score=%0d head=(%0d,%0d) want 1 3 0 (10,5)", game_state, body_len, score, head_x, head_y);
        else n_pass++;
        wait_step(n);
        body_add = 1'b1;
        tick();
        body_add = 1'b0;
        repeat (STEP - 2) tick();
        body_hit = 1'b1;
        tick();
        body_hit = 1'b0;
        n_total++;
        if ({step_tick, game_state, head_x, head_y, body_len} !== {1'b1, 2'd2, 6'd11, 6'd5, 6'd4})
            $display("FAIL body_hit tick=%0b state=%0d head=(%0d,%0d) len=%0d want 1 2 (11,5) 4", step_tick, game_state, head_x, head_y, body_len);
        else n_pass++;
        wait_step(n);
        n_total++;
        if ({game_state, flash} !== {2'd2, 1'b1})
            $display("FAIL hit_flash state=%0d flash=%0b want 2 1", game_state, flash);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({game_state, flash, step_tick, dir, head_x, head_y, body_len, score} !==
            {2'd0, 1'b0, 1'b0, 2'd3, 6'd10, 6'd5, 6'd3, 8'd0})
            $display("FAIL async_reset state=%0d flash=%0b tick=%0b dir=%0d head=(%0d,%0d) len=%0d score=%0d",
                     game_state, flash, step_tick, dir, head_x, head_y, body_len, score);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

`ifdef SNAKE_SPEEDUP_EN
    task automatic test_speedup();
        int n;
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        body_add = 1'b1;
        repeat (4) tick();
        body_add = 1'b0;
        wait_step(n);
        n_total++;
        if (n !== STEP - 4)
            $display("FAIL speedup_first_period got %0d want %0d", n, STEP - 4);
        else n_pass++;
        wait_step(n);
        n_total++;
        if (n !== 60)
            $display("FAIL speedup_4_apples got %0d want 60", n);
        else n_pass++;
        body_add = 1'b1;
        repeat (44) tick();
        body_add = 1'b0;
        n_total++;
        if ({body_len, score} !== {6'd32, 8'd48})
            $display("FAIL speedup_len_sat got %0d/%0d want 32/48", body_len, score);
        else n_pass++;
        wait_step(n);
        wait_step(n);
        wait_step(n);
        n_total++;
        if (n !== 16)
            $display("FAIL speedup_floor got %0d want 16", n);
        else n_pass++;
        wait_step(n);
        n_total++;
        if (n !== 16)
            $display("FAIL speedup_floor_hold got %0d want 16", n);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_idle();
        test_start();
        test_direction();
        test_grow();
        test_wall_die();
        test_over();
        test_body_hit_reset();
`ifdef SNAKE_SPEEDUP_EN
        test_speedup();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/snake_game_ctrl.md
# snake_game_ctrl

Central sequencer for the greedy-snake game. Owns the game state machine, the step timer, the movement direction and the head coordinate. It turns debounced key pulses into movement, detects wall and body collisions, and tracks body length and score from the apple generator's grow pulse. Its outputs feed the body shift register, the apple generator (`Head_x`/`Head_y`) and the VGA renderer.

## Interface
Parameters:
- `STEP_CYCLES`, 12_500_000: clocks per movement step (0.25 s at 50 MHz).
- `X_MAX`, 38: last legal column. Legal columns are 1..X_MAX; walls are at 0 and X_MAX+1.
- `Y_MAX`, 28: last legal row. Legal rows are 1..Y_MAX.
- `START_X`, 10 and `START_Y`, 5: head position after reset and on restart.
- `LEN_MAX`, 32: body length saturation value.
- `DIE_STEPS`, 8: number of steps the death flash lasts.

Ports:
- `Clk_50mhz` in 1: system clock.
- `Rst_n` in 1: asynchronous, active-low reset.
- `Key_up`, `Key_down`, `Key_left`, `Key_right` in 1 each: debounced single-cycle pulses.
- `Key_start` in 1: single-cycle pulse.
- `Body_add_sig` in 1: grow pulse from the apple generator.
- `Body_hit` in 1: from the body module; high when the head overlaps any body segment.
- `Game_state` out 2: 0 IDLE, 1 PLAY, 2 DIE, 3 OVER.
- `Head_x` out 6, `Head_y` out 6: head coordinate.
- `Dir` out 2: direction. 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT.
- `Step_tick` out 1: one-cycle pulse per step. It is the body shift enable.
- `Body_len` out 6: body length in segments.
- `Score` out 8: apples eaten, saturates at 255.
- `Flash` out 1: renderer blink control during DIE.

## Operation
- Reset values: IDLE, `Head`=(START_X, START_Y), `Dir`=RIGHT, `Step_tick`=0, `Body_len`=3, `Score`=0, `Flash`=0. The pending-direction register resets to RIGHT.
- IDLE:
  - Timer is held at 0 and keys are ignored.
  - `Key_start` moves to PLAY. On entry, head, Dir, Body_len and Score are reloaded with their reset values and the timer is cleared.
- PLAY:
  - A key sets the pending direction unless it is the exact reverse of the current `Dir`. A reverse key is ignored.
  - If several keys pulse in the same cycle, priority is up > down > left > right.
  - The last accepted key before a step wins.
  - On a step: `Dir` takes the pending value and the next head is `Head` ±1 on one axis.
  - If the next head falls outside 1..X_MAX or 1..Y_MAX, or `Body_hit` is high on the step cycle, the state moves to DIE. The head is not updated.
  - Otherwise the head takes the next value.
- DIE:
  - The timer keeps running. `Flash` toggles on every step and the head is frozen.
  - After DIE_STEPS steps the state moves to OVER with `Flash`=0.
- OVER:
  - Timer is held. Head, Score and Body_len hold their values for display.
  - `Key_start` moves to IDLE.
- `Body_add_sig` is honoured only in PLAY. It increments `Body_len` (saturating at LEN_MAX) and `Score` (saturating at 255). It is independent of the step and may coincide with a step.
- `Key_start` is ignored in PLAY and DIE.

## Timing
- The timer counts 0..STEP_CYCLES-1. `Step_tick` is registered and asserts for exactly one cycle, on the cycle after the counter reaches STEP_CYCLES-1.
- Head, Dir and the state update on the same clock edge that raises `Step_tick`. The new values are therefore visible while `Step_tick` is high.
- From entry into PLAY to the first `Step_tick` is STEP_CYCLES cycles.
- A key pulse on the cycle that reaches STEP_CYCLES-1 is applied on that step.
- All outputs are registered, with no combinational input-to-output path.
- Asserting `Rst_n` low mid-game returns all outputs to their reset values immediately (asynchronous reset).

## Configuration
- `SNAKE_SPEEDUP_EN` defined:
  - Every 4th apple reduces the step period by STEP_CYCLES/16, with a floor of STEP_CYCLES/4.
  - The period is reloaded to STEP_CYCLES on entry to PLAY.
  - The new period takes effect at the next timer wrap.
- `SNAKE_SPEEDUP_EN` undefined: the period is fixed at STEP_CYCLES and no period register exists.

## Structure
- Shared package `snake_pkg` holds:
  - state encodings: IDLE, PLAY, DIE, OVER;
  - direction encodings: UP, DOWN, LEFT, RIGHT;
  - the 6-bit coordinate width.
- The body, apple and VGA modules import the same package.
- One sub-module, `snake_step_timer`:
  - inputs: run enable, clear, period;
  - output: registered `Step_tick`.
- Both the FSM and the datapath stay in the top module.

## Test plan
The bench uses STEP_CYCLES=8, DIE_STEPS=2.
- Reset, then `Key_start` → PLAY, head (10,5); after 8 cycles `Step_tick` rises and the head is (11,5).
- In PLAY with Dir=RIGHT, pulse `Key_left` → Dir stays RIGHT and the head goes to (12,5). Then pulse `Key_up` and `Key_down` in the same cycle → the next step gives Dir=UP and head (12,4).
- Drive the head to (38,y) with Dir=RIGHT, then step → DIE, head holds at x=38. `Flash` toggles twice, then OVER. `Key_start` → IDLE.
- Pulse `Body_add_sig` three times in PLAY → Body_len=6, Score=3. A pulse during OVER → no change.
- Raise `Body_hit` on a step cycle → DIE on that edge. Deassert `Rst_n` mid-DIE → IDLE, `Flash`=0, head (10,5) asynchronously.
- With `SNAKE_SPEEDUP_EN` and STEP_CYCLES=64: after 4 apples, the step spacing is 60 cycles from the next wrap onward. After 48 apples, the spacing holds at 16.
